// File: rtl/intr_timegen_multi.sv
// Multi-channel interrupt / time generator sharing one 64-bit sample counter.
// Optional every-second-firing outputs are enabled with the INTR_DIV2_EN macro.
module intr_timegen_multi #(
    parameter int N_CH  = 4,
    parameter int PER_W = 24,
    parameter int DUR_W = 16,
    parameter int CH_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 time_enable,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [PER_W-1:0]     cfg_per,
    input  logic [DUR_W-1:0]     cfg_dur,
    input  logic [2:0]           cfg_ctrl,
`ifdef INTR_DIV2_EN
    input  logic [7:0]           cfg_dur2,
    input  logic [N_CH-1:0]      fix_div2_clear,
    output logic [N_CH-1:0]      intr_div2,
    output logic [N_CH-1:0]      fix_div2,
`endif
    input  logic [N_CH-1:0]      intr_release,
    output logic [63:0]          smpl_cnt,
    output logic [N_CH-1:0]      fix_pulse,
    output logic [N_CH-1:0]      intr,
    output logic [32*N_CH-1:0]   intr_cnt,
    output logic [64*N_CH-1:0]   time_cap
);

    logic [63:0] smpl_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smpl_cnt_q <= '0;
        end else if (time_enable) begin
            smpl_cnt_q <= smpl_cnt_q + 64'd1;
        end
    end

    assign smpl_cnt = smpl_cnt_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [PER_W-1:0] per_q;
        logic [DUR_W-1:0] dur_q;
        logic             type_q, pol_q, en_q;
        logic [PER_W-1:0] cnt_q, cnt_d;
        logic [DUR_W-1:0] dcnt_q, dcnt_d;
        logic             act_q, act_d;
        logic             fix_q, intr_q;
        logic [31:0]      icnt_q;
        logic [63:0]      tcap_q;
        logic             sel, fire, pol_n;

        // Out-of-range channel selects match no k, so those writes fall through.
        assign sel   = cfg_we && (cfg_ch == CH_W'(k));
        assign fire  = en_q && (cnt_q == per_q) && !sel;
        assign pol_n = sel ? cfg_ctrl[1] : pol_q;

        always_comb begin
            cnt_d  = cnt_q;
            dcnt_d = dcnt_q;
            act_d  = act_q;
            if (sel || !en_q) begin
                cnt_d  = '0;
                dcnt_d = '0;
                act_d  = 1'b0;
            end else if (fire) begin
                cnt_d  = '0;
                dcnt_d = dur_q;
                act_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (type_q) begin
                    if (intr_release[k]) act_d = 1'b0;
                end else if (act_q) begin
                    if (dcnt_q != '0) dcnt_d = dcnt_q - 1'b1;
                    else              act_d  = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                per_q  <= '0;
                dur_q  <= '0;
                type_q <= 1'b0;
                pol_q  <= 1'b0;
                en_q   <= 1'b0;
                cnt_q  <= '0;
                dcnt_q <= '0;
                act_q  <= 1'b0;
                fix_q  <= 1'b0;
                intr_q <= 1'b0;
                icnt_q <= '0;
                tcap_q <= '0;
            end else begin
                if (sel) begin
                    per_q  <= cfg_per;
                    dur_q  <= cfg_dur;
                    type_q <= cfg_ctrl[2];
                    pol_q  <= cfg_ctrl[1];
                    en_q   <= cfg_ctrl[0];
                end
                cnt_q  <= cnt_d;
                dcnt_q <= dcnt_d;
                act_q  <= act_d;
                fix_q  <= fire;
                intr_q <= act_d ^ pol_n;
                if (fire) begin
                    icnt_q <= icnt_q + 32'd1;
                    tcap_q <= smpl_cnt_q;
                end
            end
        end

        assign fix_pulse[k]         = fix_q;
        assign intr[k]              = intr_q;
        assign intr_cnt[32*k +: 32] = icnt_q;
        assign time_cap[64*k +: 64] = tcap_q;

`ifdef INTR_DIV2_EN
        logic [7:0] dur2_q;
        logic [7:0] d2cnt_q, d2cnt_d;
        logic       par_q, act2_q, act2_d, fd2_q, id2_q;
        logic       second;

        // par_q is set after an odd number of firings since the last write.
        assign second = fire && par_q;

        always_comb begin
            d2cnt_d = d2cnt_q;
            act2_d  = act2_q;
            if (sel || !en_q) begin
                d2cnt_d = '0;
                act2_d  = 1'b0;
            end else if (second) begin
                d2cnt_d = dur2_q;
                act2_d  = 1'b1;
            end else if (act2_q) begin
                if (d2cnt_q != '0) d2cnt_d = d2cnt_q - 1'b1;
                else               act2_d  = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dur2_q  <= '0;
                d2cnt_q <= '0;
                par_q   <= 1'b0;
                act2_q  <= 1'b0;
                fd2_q   <= 1'b0;
                id2_q   <= 1'b0;
            end else begin
                if (sel) begin
                    dur2_q <= cfg_dur2;
                    par_q  <= 1'b0;
                end else if (fire) begin
                    par_q  <= ~par_q;
                end
                d2cnt_q <= d2cnt_d;
                act2_q  <= act2_d;
                fd2_q   <= second | (fd2_q & ~fix_div2_clear[k]);
                id2_q   <= act2_d ^ pol_n;
            end
        end

        assign intr_div2[k] = id2_q;
        assign fix_div2[k]  = fd2_q;
`endif
    end

endmodule
